regfile_checker: RTL
====================

Name: regfile_checker

Overview:
- Synthesizable run-and-verify harness wrapped around the processor/regfile pair.
- Lets the processor run for a programmed number of cycles and counts register writebacks.
- Then takes over one regfile read port, scans every register, and compares each against an expected-value ROM.
- Reports pass/fail, error count and first-mismatch details; parametrised in data width, register count and cycle budget.

Parameters:
- DATA_W, 32, register/expected data width.
- NUM_REGS, 32, registers scanned; power of two, >= 2.
- ADDR_W, 5, register index width; equals log2(NUM_REGS).
- CYC_W, 16, width of the cycle budget and cycle counter.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- num_cycles  in  CYC_W  cycle budget, sampled when start is accepted.
- run_en  out  1  processor enable; high only in RUN.
- rwe  in  1  processor regfile write enable.
- rd  in  ADDR_W  processor write register index.
- test_mode  out  1  steers the regfile read-port-A mux to test_reg.
- test_reg  out  ADDR_W  register index being scanned.
- reg_data  in  DATA_W  regfile port-A data; combinational, same cycle as test_reg.
- exp_addr  out  ADDR_W  expected-ROM address.
- exp_data  in  DATA_W  expected-ROM data; 1-cycle registered latency.
- busy  out  1  high in RUN and SCAN.
- done  out  1  high in DONE.
- pass  out  1  valid in DONE; high when err_count == 0.
- wr_count  out  CYC_W  qualified writes seen during RUN.
- err_count  out  ADDR_W+1  number of mismatching registers.
- first_err_reg  out  ADDR_W  index of the first mismatching register.
- first_err_exp  out  DATA_W  expected value of the first mismatch.
- first_err_act  out  DATA_W  actual value of the first mismatch.

Behaviour:
- Reset (reset low, async): state IDLE; every output and counter is 0, including run_en, test_mode, busy, done, pass and all first_err_* fields.
- IDLE:
  - start=1 latches num_cycles, clears wr_count, err_count and first_err_*.
  - Goes to RUN, or straight to SCAN when num_cycles == 0.
- RUN:
  - run_en=1; the cycle counter increments each clock.
  - wr_count increments on each cycle with rwe=1 and rd != 0; it saturates at all-ones.
  - After exactly num_cycles RUN cycles, goes to SCAN; run_en falls on the same edge.
- SCAN:
  - test_mode=1; scan index k runs 0..NUM_REGS-1, one register per cycle, with test_reg=exp_addr=k.
  - Stage 1 captures reg_data and k.
  - Stage 2, next cycle: compares the captured value against exp_data.
  - On a mismatch, err_count increments; on the first mismatch only, first_err_* are loaded.
  - Register 0 is compared like any other register.
  - SCAN lasts NUM_REGS+1 cycles, the last one draining the pipeline; then goes to DONE.
  - test_mode drops on entry to DONE.
- DONE:
  - done=1; pass = (err_count == 0); all results hold.
  - start=1 restarts exactly as from IDLE, with results cleared on the same edge.
- start is ignored in RUN and SCAN.
- Asserting reset mid-RUN or mid-SCAN aborts immediately to IDLE; partial results are discarded.
- err_count never wraps; its maximum is NUM_REGS.

Optional Feature:
- Macro: REGFILE_CHECKER_TRACE_EN.
- Defined: adds ports trace_valid (out 1), trace_cycle (out CYC_W), trace_rd (out ADDR_W), trace_data (out DATA_W), and input data_writeReg (DATA_W).
  - For each qualified RUN write, the trace port presents the RUN cycle index, rd and data, registered one cycle later.
  - trace_valid is a single-cycle pulse; all trace outputs reset to 0.
- Undefined: none of these ports exist; wr_count still operates.

Decomposition:
- Shared package regfile_checker_pkg holds:
  - state encoding IDLE=0, RUN=1, SCAN=2, DONE=3;
  - default width constants.
- One natural sub-module, regfile_checker_cmp: the two-stage capture/compare pipeline with error counter and first-error latch.
- The FSM and counters stay in the top module.

Test Plan:
- All-match: num_cycles=10, ROM equals regfile contents -> run_en high exactly 10 cycles, done after 10+33 cycles, pass=1, err_count=0.
- Writes: rwe pulses at rd=0, 3, 7 in RUN, plus rwe with rd=5 while in SCAN -> wr_count=2.
- Mismatches: reg4 expected 0x11 but holds 0x12, reg9 also mismatches -> err_count=2, first_err_reg=4, first_err_exp=0x11, first_err_act=0x12, pass=0.
- Zero budget: num_cycles=0 -> run_en never asserted, SCAN begins the cycle after start.
- Abort: reset low during SCAN at k=6 -> all outputs 0 asynchronously; start after release yields a clean full run.
- Restart: start pulsed in DONE, and again mid-RUN -> the DONE start clears results and reruns; the mid-RUN start is ignored and cycle count is unchanged.

Source files
------------

// File: rtl/regfile_checker_pkg.sv
// Shared state encoding and default widths for the regfile run-and-verify harness.
package regfile_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_CYC_W    = 16;

endpackage

// File: rtl/regfile_checker_cmp.sv
// Two-stage capture/compare pipeline with saturating error counter and first-error latch.
module regfile_checker_cmp
  import regfile_checker_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              cap_en,
  input  logic              drain_last,
  input  logic [ADDR_W-1:0] cap_idx,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_reg,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              pass
);

  localparam int unsigned ERR_W = ADDR_W + 1;

  logic              cap_valid_q, cap_valid_d;
  logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_reg_q, first_err_reg_d;
  logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
  logic [DATA_W-1:0] first_err_act_q, first_err_act_d;
  logic              pass_q, pass_d;
  logic              mismatch_c;

  // Stage 1 captures the read-port data; stage 2 meets the ROM data one cycle later.
  always_comb begin
    cap_valid_d     = cap_en;
    cap_idx_d       = cap_idx_q;
    cap_data_d      = cap_data_q;
    err_count_d     = err_count_q;
    first_err_reg_d = first_err_reg_q;
    first_err_exp_d = first_err_exp_q;
    first_err_act_d = first_err_act_q;
    pass_d          = pass_q;
    mismatch_c      = cap_valid_q && (cap_data_q != exp_data);

    if (cap_en) begin
      cap_idx_d  = cap_idx;
      cap_data_d = reg_data;
    end

    if (mismatch_c) begin
      if (err_count_q != ERR_W'(NUM_REGS)) err_count_d = err_count_q + ERR_W'(1);
      if (err_count_q == '0) begin
        first_err_reg_d = cap_idx_q;
        first_err_exp_d = exp_data;
        first_err_act_d = cap_data_q;
      end
    end

    // Verdict includes the compare retiring on the drain cycle itself.
    if (drain_last) pass_d = (err_count_d == '0);

    if (clear) begin
      cap_valid_d     = 1'b0;
      err_count_d     = '0;
      first_err_reg_d = '0;
      first_err_exp_d = '0;
      first_err_act_d = '0;
      pass_d          = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_valid_q     <= 1'b0;
      cap_idx_q       <= '0;
      cap_data_q      <= '0;
      err_count_q     <= '0;
      first_err_reg_q <= '0;
      first_err_exp_q <= '0;
      first_err_act_q <= '0;
      pass_q          <= 1'b0;
    end else begin
      cap_valid_q     <= cap_valid_d;
      cap_idx_q       <= cap_idx_d;
      cap_data_q      <= cap_data_d;
      err_count_q     <= err_count_d;
      first_err_reg_q <= first_err_reg_d;
      first_err_exp_q <= first_err_exp_d;
      first_err_act_q <= first_err_act_d;
      pass_q          <= pass_d;
    end
  end

  assign err_count     = err_count_q;
  assign first_err_reg = first_err_reg_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_act = first_err_act_q;
  assign pass          = pass_q;

endmodule

// File: rtl/regfile_checker.sv
// Run-and-verify harness: runs the processor for a cycle budget, then scans the regfile against a ROM.
// Optional write-trace port enabled by REGFILE_CHECKER_TRACE_EN.
module regfile_checker
  import regfile_checker_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned CYC_W    = DEF_CYC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  output logic              run_en,
  input  logic              rwe,
  input  logic [ADDR_W-1:0] rd,
  output logic              test_mode,
  output logic [ADDR_W-1:0] test_reg,
  input  logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CYC_W-1:0]  wr_count,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_reg,
  output logic [DATA_W-1:0] first_err_exp,
`ifdef REGFILE_CHECKER_TRACE_EN
  input  logic [DATA_W-1:0] data_writeReg,
  output logic              trace_valid,
  output logic [CYC_W-1:0]  trace_cycle,
  output logic [ADDR_W-1:0] trace_rd,
  output logic [DATA_W-1:0] trace_data,
`endif
  output logic [DATA_W-1:0] first_err_act
);

  localparam int unsigned SCAN_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  budget_q, budget_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [CYC_W-1:0]  wr_count_q, wr_count_d;
  logic              run_en_q, run_en_d;
  logic              test_mode_q, test_mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear_c, cap_en_c, drain_last_c, wr_qual_c;

  assign wr_qual_c = (state_q == ST_RUN) && rwe && (rd != '0);

  // Next-state, counters and registered status outputs.
  always_comb begin
    state_d      = state_q;
    budget_d     = budget_q;
    cyc_d        = cyc_q;
    scan_d       = scan_q;
    wr_count_d   = wr_count_q;
    clear_c      = 1'b0;
    cap_en_c     = 1'b0;
    drain_last_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_c    = 1'b1;
          budget_d   = num_cycles;
          cyc_d      = '0;
          scan_d     = '0;
          wr_count_d = '0;
          state_d    = (num_cycles == '0) ? ST_SCAN : ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (wr_qual_c && (wr_count_q != '1)) wr_count_d = wr_count_q + CYC_W'(1);
        if (cyc_q == budget_q - CYC_W'(1)) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Index NUM_REGS is the drain cycle: nothing captured, last compare retires.
        if (scan_q == SCAN_W'(NUM_REGS)) begin
          drain_last_c = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cap_en_c = 1'b1;
          scan_d   = scan_q + SCAN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_en_d    = (state_d == ST_RUN);
    test_mode_d = (state_d == ST_SCAN);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_SCAN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      budget_q    <= '0;
      cyc_q       <= '0;
      scan_q      <= '0;
      wr_count_q  <= '0;
      run_en_q    <= 1'b0;
      test_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      budget_q    <= budget_d;
      cyc_q       <= cyc_d;
      scan_q      <= scan_d;
      wr_count_q  <= wr_count_d;
      run_en_q    <= run_en_d;
      test_mode_q <= test_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign run_en    = run_en_q;
  assign test_mode = test_mode_q;
  assign test_reg  = scan_q[ADDR_W-1:0];
  assign exp_addr  = scan_q[ADDR_W-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_count  = wr_count_q;

  regfile_checker_cmp #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_cmp (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear_c),
    .cap_en       (cap_en_c),
    .drain_last   (drain_last_c),
    .cap_idx      (scan_q[ADDR_W-1:0]),
    .reg_data     (reg_data),
    .exp_data     (exp_data),
    .err_count    (err_count),
    .first_err_reg(first_err_reg),
    .first_err_exp(first_err_exp),
    .first_err_act(first_err_act),
    .pass         (pass)
  );

`ifdef REGFILE_CHECKER_TRACE_EN
  logic              trace_valid_q, trace_valid_d;
  logic [CYC_W-1:0]  trace_cycle_q, trace_cycle_d;
  logic [ADDR_W-1:0] trace_rd_q, trace_rd_d;
  logic [DATA_W-1:0] trace_data_q, trace_data_d;

  // One-cycle-delayed record of each qualified RUN write.
  always_comb begin
    trace_valid_d = wr_qual_c;
    trace_cycle_d = trace_cycle_q;
    trace_rd_d    = trace_rd_q;
    trace_data_d  = trace_data_q;
    if (wr_qual_c) begin
      trace_cycle_d = cyc_q;
      trace_rd_d    = rd;
      trace_data_d  = data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_valid_q <= 1'b0;
      trace_cycle_q <= '0;
      trace_rd_q    <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_cycle_q <= trace_cycle_d;
      trace_rd_q    <= trace_rd_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_cycle = trace_cycle_q;
  assign trace_rd    = trace_rd_q;
  assign trace_data  = trace_data_q;
`endif

endmodule
